// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM generator that sits behind the frequency divider.
package pwm_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_t;

endpackage

// File: rtl/pwm_generator_tick_edge_detect.sv
// Turns the divider's level-toggling `counting` output into a one-clk step enable.
// Any edge of tick_in, rising or falling, produces exactly one step.
module tick_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic tick_in,
  output logic step
);

  logic tick_q;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_q <= 1'b0;
    else       tick_q <= tick_in;
  end

  assign step = tick_in ^ tick_q;

endmodule

// File: rtl/pwm_generator.sv
// PWM generator clocked by divider steps, with double-buffered period/duty that
// change only at period boundaries while running.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick_in,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  input  logic             load,
  output logic             pwm_out,
  output logic             period_done,
  output logic             running
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  pwm_state_t       state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] period_r, period_nxt;
  logic [WIDTH-1:0] duty_r, duty_nxt;
  logic [WIDTH-1:0] shadow_period, shadow_period_nxt;
  logic [WIDTH-1:0] shadow_duty, shadow_duty_nxt;
  logic             pending, pending_nxt;
  logic             pwm_nxt, done_nxt;
  logic             step;

  tick_edge_detect u_tick_edge_detect (
    .clk     (clk),
    .reset   (reset),
    .tick_in (tick_in),
    .step    (step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      period_r      <= '0;
      duty_r        <= '0;
      shadow_period <= '0;
      shadow_duty   <= '0;
      pending       <= 1'b0;
      pwm_out       <= 1'b0;
      period_done   <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      period_r      <= period_nxt;
      duty_r        <= duty_nxt;
      shadow_period <= shadow_period_nxt;
      shadow_duty   <= shadow_duty_nxt;
      pending       <= pending_nxt;
      pwm_out       <= pwm_nxt;
      period_done   <= done_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_nxt         = state;
    cnt_nxt           = cnt;
    period_nxt        = period_r;
    duty_nxt          = duty_r;
    shadow_period_nxt = shadow_period;
    shadow_duty_nxt   = shadow_duty;
    pending_nxt       = pending;
    pwm_nxt           = pwm_out;
    done_nxt          = 1'b0;

    if (load) begin
      shadow_period_nxt = period;
      shadow_duty_nxt   = duty;
    end

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        pwm_nxt = 1'b0;
        // Nothing is being generated, so new settings can go live immediately.
        if (load) begin
          period_nxt  = period;
          duty_nxt    = duty;
          pending_nxt = 1'b0;
        end else if (pending) begin
          period_nxt  = shadow_period;
          duty_nxt    = shadow_duty;
          pending_nxt = 1'b0;
        end
        if (enable && period_r != '0) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          pwm_nxt   = (duty_r != '0);
        end
      end

      RUN: begin
        if (load) pending_nxt = 1'b1;
        if (!enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          pwm_nxt   = 1'b0;
        end else if (step) begin
          if (cnt == period_r - ONE) begin
            cnt_nxt  = '0;
            done_nxt = 1'b1;
            // A load landing on the wrap clk bypasses the shadow entirely.
            if (load) begin
              period_nxt  = period;
              duty_nxt    = duty;
              pending_nxt = 1'b0;
            end else if (pending) begin
              period_nxt  = shadow_period;
              duty_nxt    = shadow_duty;
              pending_nxt = 1'b0;
            end
          end else begin
            cnt_nxt = cnt + ONE;
          end
          pwm_nxt = (cnt_nxt < duty_nxt);
          if (period_nxt == '0) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            pwm_nxt   = 1'b0;
          end
        end
      end
    endcase
  end

  assign running = (state == RUN);

endmodule
